// File: rtl/trade_history.sv
`default_nettype none
// =====================================================================
// Module   : trade_history
// Purpose  : Ring buffer of recent trade prices with windowed statistics
//            (last, trend, floor average, min, max) and a registered
//            random-access read port. Define TRADE_HIST_MINMAX_EN to
//            enable the min/max scan stage.
// Revision : 1.0
// =====================================================================
module trade_history #(
    parameter int DEPTH   = 8,
    parameter int PRICE_W = 8
) (
    input  logic                     clk_50,
    input  logic                     reset,
    input  logic                     trade_valid,
    input  logic [PRICE_W-1:0]       trade_price,
    input  logic                     halt,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [PRICE_W-1:0]       rd_price,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic [PRICE_W-1:0]       last_price,
    output logic [1:0]               trend,
    output logic [PRICE_W-1:0]       avg_price,
    output logic [PRICE_W-1:0]       min_price,
    output logic [PRICE_W-1:0]       max_price,
    output logic                     stats_busy
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int SUM_W   = PRICE_W + IDX_W;
    localparam int CNT_MAX = (DEPTH > SUM_W) ? DEPTH : SUM_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W:0]   C_DEPTH     = (IDX_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] C_SCAN_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DIV_LAST  = CNT_W'(SUM_W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_DIV    = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

`ifdef TRADE_HIST_MINMAX_EN
    localparam state_t C_START = S_SCAN;
`else
    localparam state_t C_START = S_DIV;
`endif

    logic [PRICE_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]   r_wr_ptr;
    logic [IDX_W:0]     r_count;
    logic [SUM_W-1:0]   r_sum;
    logic [PRICE_W-1:0] r_last;
    logic [1:0]         r_trend;
    logic [PRICE_W-1:0] r_avg;
    logic [PRICE_W-1:0] r_rd_price;
    logic               r_rd_valid;
    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [SUM_W-1:0]   r_quot;
    logic [IDX_W:0]     r_div;
    logic [IDX_W:0]     r_rem;

    logic               w_accept;
    logic               w_full;
    logic [IDX_W-1:0]   w_wr_ptr_next;
    logic [IDX_W:0]     w_count_next;
    logic [SUM_W-1:0]   w_sum_next;
    logic [1:0]         w_trend_next;
    logic [IDX_W-1:0]   w_rd_slot;
    logic [PRICE_W-1:0] w_rd_data;
    logic               w_rd_hit;
    logic [IDX_W+1:0]   w_rem_sh;
    logic [IDX_W+1:0]   w_rem_trial;
    logic               w_ge;

    assign w_accept      = trade_valid & ~halt;
    assign w_full        = (r_count == C_DEPTH);
    assign w_wr_ptr_next = w_accept ? r_wr_ptr + IDX_W'(1) : r_wr_ptr;
    assign w_count_next  = (w_accept && !w_full) ? r_count + (IDX_W+1)'(1) : r_count;
    // Modular arithmetic: the intermediate may wrap, the final window sum never does.
    assign w_sum_next    = r_sum + SUM_W'(trade_price)
                         - (w_full ? SUM_W'(r_mem[r_wr_ptr]) : SUM_W'(0));

    always_comb begin
        w_trend_next = 2'b00;
        if (r_count != '0) begin
            if (trade_price > r_last)      w_trend_next = 2'b01;
            else if (trade_price < r_last) w_trend_next = 2'b10;
        end
    end

    // Reads see the post-accept ordering, so a same-cycle write is forwarded.
    assign w_rd_slot = w_wr_ptr_next - IDX_W'(1) - rd_idx;
    assign w_rd_hit  = ({1'b0, rd_idx} < w_count_next);
    assign w_rd_data = (w_accept && (w_rd_slot == r_wr_ptr)) ? trade_price : r_mem[w_rd_slot];

    // Restoring divider step; the trial's sign bit is the borrow.
    assign w_rem_sh    = {r_rem, r_quot[SUM_W-1]};
    assign w_rem_trial = w_rem_sh - {1'b0, r_div};
    assign w_ge        = ~w_rem_trial[IDX_W+1];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   w_state_next = S_IDLE;
            S_SCAN:   if (r_cnt == C_SCAN_LAST) w_state_next = S_DIV;
            S_DIV:    if (r_cnt == C_DIV_LAST)  w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        if (w_accept) w_state_next = C_START;
    end

    always_ff @(posedge clk_50) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_sum      <= '0;
            r_last     <= '0;
            r_trend    <= '0;
            r_rd_price <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= trade_price;
                r_wr_ptr        <= w_wr_ptr_next;
                r_count         <= w_count_next;
                r_sum           <= w_sum_next;
                r_last          <= trade_price;
                r_trend         <= w_trend_next;
            end
            r_rd_valid <= w_rd_hit;
            r_rd_price <= w_rd_hit ? w_rd_data : '0;
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_cnt  <= '0;
            r_quot <= '0;
            r_div  <= '0;
            r_rem  <= '0;
            r_avg  <= '0;
        end else begin
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == S_SCAN && r_cnt == C_SCAN_LAST)
                r_cnt <= '0;
            else if (r_state == S_SCAN || r_state == S_DIV)
                r_cnt <= r_cnt + CNT_W'(1);

            if (w_accept) begin
                r_quot <= w_sum_next;
                r_div  <= w_count_next;
                r_rem  <= '0;
            end else if (r_state == S_DIV) begin
                r_quot <= {r_quot[SUM_W-2:0], w_ge};
                r_rem  <= w_ge ? w_rem_trial[IDX_W:0] : w_rem_sh[IDX_W:0];
            end

            if (r_state == S_COMMIT && !w_accept)
                r_avg <= r_quot[PRICE_W-1:0];
        end
    end

`ifdef TRADE_HIST_MINMAX_EN
    logic [PRICE_W-1:0] r_smin;
    logic [PRICE_W-1:0] r_smax;
    logic [PRICE_W-1:0] r_min;
    logic [PRICE_W-1:0] r_max;
    logic [IDX_W-1:0]   w_scan_age;
    logic [IDX_W-1:0]   w_scan_slot;
    logic [PRICE_W-1:0] w_scan_val;
    logic               w_scan_live;

    // The scan walks by age, so liveness is simply age < count.
    assign w_scan_age  = r_cnt[IDX_W-1:0];
    assign w_scan_slot = r_wr_ptr - IDX_W'(1) - w_scan_age;
    assign w_scan_val  = r_mem[w_scan_slot];
    assign w_scan_live = ({1'b0, w_scan_age} < r_count);

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_smin <= '0;
            r_smax <= '0;
            r_min  <= '0;
            r_max  <= '0;
        end else begin
            if (w_accept) begin
                r_smin <= '1;
                r_smax <= '0;
            end else if (r_state == S_SCAN && w_scan_live) begin
                if (w_scan_val < r_smin) r_smin <= w_scan_val;
                if (w_scan_val > r_smax) r_smax <= w_scan_val;
            end
            if (r_state == S_COMMIT && !w_accept) begin
                r_min <= r_smin;
                r_max <= r_smax;
            end
        end
    end

    assign min_price = r_min;
    assign max_price = r_max;
`else
    assign min_price = '0;
    assign max_price = '0;
`endif

    assign rd_price   = r_rd_price;
    assign rd_valid   = r_rd_valid;
    assign count      = r_count;
    assign last_price = r_last;
    assign trend      = r_trend;
    assign avg_price  = r_avg;
    assign stats_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trade_history.sv
`default_nettype none
// Testbench for trade_history: directed scenarios plus randomized trades,
// every cycle compared against a queue-based window model.
`timescale 1ns/1ps
module tb_trade_history;
    localparam int DEPTH   = 8;
    localparam int PRICE_W = 8;
    localparam int IDX_W   = 3;
    localparam int SUM_W   = PRICE_W + IDX_W;
`ifdef TRADE_HIST_MINMAX_EN
    localparam int LAT = DEPTH + SUM_W + 1;
    localparam bit MM  = 1'b1;
`else
    localparam int LAT = SUM_W + 1;
    localparam bit MM  = 1'b0;
`endif

    logic               clk_50 = 1'b0;
    logic               reset;
    logic               trade_valid;
    logic [PRICE_W-1:0] trade_price;
    logic               halt;
    logic [IDX_W-1:0]   rd_idx;
    logic [PRICE_W-1:0] rd_price;
    logic               rd_valid;
    logic [IDX_W:0]     count;
    logic [PRICE_W-1:0] last_price;
    logic [1:0]         trend;
    logic [PRICE_W-1:0] avg_price;
    logic [PRICE_W-1:0] min_price;
    logic [PRICE_W-1:0] max_price;
    logic               stats_busy;

    always #5 clk_50 = ~clk_50;

    trade_history #(.DEPTH(DEPTH), .PRICE_W(PRICE_W)) dut (
        .clk_50(clk_50), .reset(reset), .trade_valid(trade_valid),
        .trade_price(trade_price), .halt(halt), .rd_idx(rd_idx),
        .rd_price(rd_price), .rd_valid(rd_valid), .count(count),
        .last_price(last_price), .trend(trend), .avg_price(avg_price),
        .min_price(min_price), .max_price(max_price), .stats_busy(stats_busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: hist[0] is the newest price; committed stats and a countdown to commit.
    int hist[$];
    int m_last, m_trend, m_avg, m_min, m_max, m_rem, m_rd_idx;
    int n, p, gap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_commit();
        int s, mn, mx;
        s = 0; mn = 255; mx = 0;
        foreach (hist[i]) begin
            s += hist[i];
            if (hist[i] < mn) mn = hist[i];
            if (hist[i] > mx) mx = hist[i];
        end
        m_avg = s / hist.size();
        m_min = MM ? mn : 0;
        m_max = MM ? mx : 0;
    endtask

    task automatic model_edge(input bit rst, input bit tv, input bit h, input int price, input int ridx);
        m_rd_idx = ridx;
        if (rst) begin
            hist.delete();
            m_last = 0; m_trend = 0; m_avg = 0; m_min = 0; m_max = 0; m_rem = 0;
        end else if (tv && !h) begin
            if (hist.size() == 0)    m_trend = 0;
            else if (price > m_last) m_trend = 1;
            else if (price < m_last) m_trend = 2;
            else                     m_trend = 0;
            m_last = price;
            hist.push_front(price);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            m_rem = LAT;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) model_commit();
        end
    endtask

    task automatic check_all();
        bit v;
        v = (m_rd_idx < hist.size());
        chk("count", count, hist.size());
        chk("last_price", last_price, m_last);
        chk("trend", trend, m_trend);
        chk("avg_price", avg_price, m_avg);
        chk("min_price", min_price, m_min);
        chk("max_price", max_price, m_max);
        chk("stats_busy", stats_busy, m_rem > 0);
        chk("rd_valid", rd_valid, v);
        chk("rd_price", rd_price, v ? hist[m_rd_idx] : 0);
    endtask

    task automatic step();
        @(posedge clk_50);
        model_edge(reset, trade_valid, halt, trade_price, rd_idx);
        #1;
        check_all();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic trade(input int price, input bit h);
        trade_valid = 1'b1; trade_price = price[PRICE_W-1:0]; halt = h;
        step();
        trade_valid = 1'b0; halt = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (stats_busy && k < 100) begin step(); k++; end
        chk("wait_idle_timeout", k < 100, 1'b1);
    endtask

    task automatic read_at(input int idx, input string tag, input bit exp_v, input int exp_p);
        rd_idx = idx[IDX_W-1:0];
        step();
        chk({tag, "_valid"}, rd_valid, exp_v);
        chk({tag, "_price"}, rd_price, exp_p);
    endtask

    initial begin
        reset = 1'b1; trade_valid = 1'b0; halt = 1'b0; trade_price = '0; rd_idx = '0;
        m_rd_idx = 0;
        do_reset();

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_last", last_price, 0);
        chk("rst_avg", avg_price, 0);
        chk("rst_trend", trend, 0);
        chk("rst_busy", stats_busy, 0);
        for (int i = 0; i < DEPTH; i++) read_at(i, "rst_rd", 1'b0, 0);

        // Fill
        trade(10, 0); idle(24);
        trade(20, 0); idle(24);
        trade(30, 0);
        chk("fill_count", count, 3);
        chk("fill_last", last_price, 30);
        chk("fill_trend", trend, 1);
        idle(LAT);
        chk("fill_avg", avg_price, 20);
        chk("fill_min", min_price, MM ? 10 : 0);
        chk("fill_max", max_price, MM ? 30 : 0);
        read_at(0, "fill_rd0", 1'b1, 30);
        read_at(1, "fill_rd1", 1'b1, 20);
        read_at(2, "fill_rd2", 1'b1, 10);
        read_at(3, "fill_rd3", 1'b0, 0);

        // Wrap / evict
        do_reset();
        for (int v = 1; v <= 9; v++) begin
            trade(v, 0);
            wait_idle();
        end
        chk("wrap_count", count, 8);
        chk("wrap_avg", avg_price, 5);
        chk("wrap_min", min_price, MM ? 2 : 0);
        chk("wrap_max", max_price, MM ? 9 : 0);
        read_at(0, "wrap_rd0", 1'b1, 9);
        read_at(7, "wrap_rd7", 1'b1, 2);
        trade(3, 0);
        chk("wrap_trend_down", trend, 2);
        wait_idle();

        // Halt
        trade(99, 1);
        chk("halt_count", count, 8);
        chk("halt_last", last_price, 3);
        chk("halt_busy", stats_busy, 0);

        // Restart mid-pipeline
        do_reset();
        trade(40, 0); idle(4);
        trade(60, 0);
        idle(LAT - 1);
        chk("restart_hold_avg", avg_price, 0);
        chk("restart_hold_busy", stats_busy, 1);
        step();
        chk("restart_avg", avg_price, 50);
        chk("restart_min", min_price, MM ? 40 : 0);
        chk("restart_max", max_price, MM ? 60 : 0);
        chk("restart_busy", stats_busy, 0);

        // Reset during the divide
        trade(77, 0);
        idle(MM ? 12 : 5);
        reset = 1'b1; step(); reset = 1'b0;
        chk("middiv_busy", stats_busy, 0);
        chk("middiv_count", count, 0);
        chk("middiv_avg", avg_price, 0);
        chk("middiv_last", last_price, 0);
        idle(LAT + 5);
        chk("middiv_no_late_commit", avg_price, 0);

        // Randomized trades, gaps, halts, reads
        for (int it = 0; it < 300; it++) begin
            p = ($urandom_range(0, 3) == 0) ? m_last : int'($urandom_range(0, 255));
            rd_idx = IDX_W'($urandom_range(0, DEPTH - 1));
            trade(p, $urandom_range(0, 7) == 0);
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
            for (int g = 0; g < gap; g++) begin
                rd_idx = IDX_W'($urandom_range(0, DEPTH - 1));
                step();
            end
        end
        n = 0;
        while (stats_busy && n < 100) begin step(); n++; end
        chk("final_idle", stats_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
